count_capture_unit: RTL and testbench



---
 rtl/count_capture_unit_pkg.sv | 23 ++
 rtl/capture_fifo.sv | 63 ++++++
 rtl/count_capture_unit.sv | 131 +++++++++++++
 tb/tb_count_capture_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_capture_unit_pkg.sv
// rtl/count_capture_unit_pkg.sv - shared encodings, FSM states and sizing helpers for count_capture_unit
package count_capture_unit_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_ARM      = 2'd1,
    ST_ACTIVE   = 2'd2
  } cap_state_e;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int unsigned CAP_DEPTH_DEF = 4;
  localparam int unsigned CAP_PTR_W_DEF = ptr_width(CAP_DEPTH_DEF);

endpackage

// File: rtl/capture_fifo.sv
// rtl/capture_fifo.sv - first-word fall-through synchronous FIFO with full, empty and level
module capture_fifo
  import count_capture_unit_pkg::*;
#(
  parameter int unsigned DW    = 17,
  parameter int unsigned DEPTH = CAP_DEPTH_DEF,
  parameter int unsigned PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [DW-1:0]    push_data_i,
  input  logic             pop_i,
  output logic [DW-1:0]    head_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PTR_W-1:0] level_o
);

  localparam int unsigned AW = PTR_W - 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  assign level_o     = wr_ptr_q - rd_ptr_q;
  assign empty_o     = (level_o == '0);
  assign full_o      = (level_o == PTR_W'(DEPTH));
  assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
  always_comb begin
    do_pop   = pop_i & ~empty_o;
    do_push  = push_i & (~full_o | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // Pointer registers; reset discards every pending entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero until the first write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/count_capture_unit.sv
// rtl/count_capture_unit.sv - synchronised edge capture of a free-running count into a FIFO
module count_capture_unit
  import count_capture_unit_pkg::*;
#(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned DEPTH       = CAP_DEPTH_DEF,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned PTR_W       = ptr_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] count_i,
  input  logic             event_i,
  input  logic [1:0]       edge_sel_i,
  output logic [WIDTH-1:0] cap_data_o,
  output logic             cap_edge_o,
  output logic             cap_valid_o,
  input  logic             cap_ready_i,
  output logic             overflow_o,
  input  logic             clear_ovf_i,
  output logic [PTR_W-1:0] level_o
);

  localparam int unsigned ARM_W = $clog2(SYNC_STAGES);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   prev_q;
  logic                   rise;
  logic                   fall;
  logic                   rise_en;
  logic                   fall_en;
  cap_state_e             state_q, state_d;
  logic [ARM_W-1:0]       arm_cnt_q, arm_cnt_d;
  logic                   capture;
  logic                   overflow_q, overflow_d;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic [WIDTH:0]         head;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~prev_q;
  assign fall    = ~s & prev_q;
  assign rise_en = (edge_sel_i == EDGE_RISE) || (edge_sel_i == EDGE_BOTH);
  assign fall_en = (edge_sel_i == EDGE_FALL) || (edge_sel_i == EDGE_BOTH);

  // Synchroniser chain and one-cycle-delayed copy; prev follows s in every state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], event_i};
      prev_q <= s;
    end
  end

  // Arming waits for the synchroniser to flush so a pre-existing high level is never an edge.
  always_comb begin
    state_d   = state_q;
    arm_cnt_d = '0;
    capture   = 1'b0;
    unique case (state_q)
      ST_DISABLED: begin
        if (edge_sel_i != EDGE_OFF) state_d = ST_ARM;
      end
      ST_ARM: begin
        if (edge_sel_i == EDGE_OFF)  state_d = ST_DISABLED;
        else if (arm_cnt_q == ARM_LAST) state_d = ST_ACTIVE;
        else arm_cnt_d = arm_cnt_q + 1'b1;
      end
      ST_ACTIVE: begin
        if (edge_sel_i == EDGE_OFF) state_d = ST_DISABLED;
        else capture = (rise & rise_en) | (fall & fall_en);
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  // FSM state and arm counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_DISABLED;
      arm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      arm_cnt_q <= arm_cnt_d;
    end
  end

  assign pop  = cap_valid_o & cap_ready_i;
  assign drop = capture & fifo_full & ~cap_ready_i;

  // Sticky overflow; a new drop beats a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    if (drop)             overflow_d = 1'b1;
    else if (clear_ovf_i) overflow_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) overflow_q <= 1'b0;
    else         overflow_q <= overflow_d;
  end

  capture_fifo #(
    .DW   (WIDTH + 1),
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (capture),
    .push_data_i({rise, count_i}),
    .pop_i      (pop),
    .head_data_o(head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (level_o)
  );

  assign cap_data_o  = head[WIDTH-1:0];
  assign cap_edge_o  = head[WIDTH];
  assign cap_valid_o = ~fifo_empty;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_count_capture_unit.sv
// tb/tb_count_capture_unit.sv - randomized and directed self-checking bench for count_capture_unit
module tb_count_capture_unit;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned S  = 2;
  localparam int unsigned LW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [W-1:0]  count;
  logic          ev;
  logic [1:0]    sel;
  logic          ready;
  logic          clr;
  logic [W-1:0]  cap_data;
  logic          cap_edge;
  logic          cap_valid;
  logic          ovf;
  logic [LW-1:0] level;

  int total = 0;
  int bad   = 0;

  count_capture_unit #(
    .WIDTH(W), .DEPTH(D), .SYNC_STAGES(S)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .count_i    (count),
    .event_i    (ev),
    .edge_sel_i (sel),
    .cap_data_o (cap_data),
    .cap_edge_o (cap_edge),
    .cap_valid_o(cap_valid),
    .cap_ready_i(ready),
    .overflow_o (ovf),
    .clear_ovf_i(clr),
    .level_o    (level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         pol;
    logic [W-1:0] cnt;
  } ent_t;

  ent_t mq[$];
  bit   hist[S+1];
  int   run;
  bit   m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i <= S; i++) hist[i] = 1'b0;
    run   = 0;
    m_ovf = 1'b0;
  endtask

  // Called once per cycle at the falling edge: compare, then predict the next rising edge.
  task automatic model_cycle();
    bit s_m, p_m, cap, pol, do_pop, was_full;
    ent_t e;
    if (!rst_n) model_reset();
    chk("valid", cap_valid, 32'(mq.size() != 0));
    chk("level", level, mq.size());
    chk("overflow", ovf, m_ovf);
    if (mq.size() != 0) begin
      chk("head_count", cap_data, mq[0].cnt);
      chk("head_edge", cap_edge, mq[0].pol);
    end
    if (rst_n) begin
      s_m      = hist[S-1];
      p_m      = hist[S];
      pol      = s_m & ~p_m;
      cap      = (run > S) && ((s_m && !p_m && sel[0]) || (!s_m && p_m && sel[1]));
      was_full = (mq.size() == D);
      do_pop   = ready && (mq.size() != 0);
      if (do_pop) void'(mq.pop_front());
      if (cap && was_full && !do_pop) m_ovf = 1'b1;
      else begin
        if (cap) begin
          e.pol = pol;
          e.cnt = count;
          mq.push_back(e);
        end
        if (clr) m_ovf = 1'b0;
      end
      run = (sel != 2'b00) ? ((run < 1000) ? run + 1 : run) : 0;
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = ev;
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    count = count + 1'b1;
  endtask

  task automatic drain();
    ready = 1'b1;
    repeat (6) step();
    ready = 1'b0;
  endtask

  logic [W-1:0] first_cnt;
  logic [W-1:0] diff;
  logic [W-1:0] exp_c[5];

  initial begin
    rst_n = 1'b0; count = '0; ev = 1'b0; sel = 2'b00; ready = 1'b0; clr = 1'b0;
    model_reset();
    repeat (3) step();
    chk("rst_valid", cap_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", cap_data, 0);
    chk("rst_edge", cap_edge, 0);

    // single rising edge, latency and stored count
    rst_n = 1'b1; sel = 2'b01;
    repeat (6) step();
    count = 16'h0010; ev = 1'b1;
    step(); step();
    chk("t1_not_yet_valid", cap_valid, 0);
    step();
    chk("t1_valid", cap_valid, 1);
    chk("t1_data", cap_data, 16'h0012);
    chk("t1_edge", cap_edge, 1);
    chk("t1_level", level, 1);
    drain();

    // five-cycle pulse on both edges
    ev = 1'b0;
    repeat (4) step();
    sel = 2'b11;
    repeat (2) step();
    ev = 1'b1;
    repeat (5) step();
    ev = 1'b0;
    repeat (4) step();
    chk("t2_level", level, 2);
    chk("t2_first_edge", cap_edge, 1);
    first_cnt = cap_data;
    ready = 1'b1; step(); ready = 1'b0;
    chk("t2_second_edge", cap_edge, 0);
    diff = cap_data - first_cnt;
    chk("t2_count_diff", diff, 5);
    drain();

    // line high through reset release is not an edge
    ev = 1'b1; rst_n = 1'b0; sel = 2'b01;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (8) step();
    chk("t3_no_entry", level, 0);
    ev = 1'b0; repeat (3) step();
    ev = 1'b1; repeat (4) step();
    chk("t3_one_entry", level, 1);
    chk("t3_edge", cap_edge, 1);
    drain();

    // overflow with five edges into a four-deep FIFO, then clear
    for (int i = 0; i < 5; i++) begin
      ev = 1'b0; repeat (2) step();
      ev = 1'b1; exp_c[i] = count + 16'd2; repeat (2) step();
    end
    repeat (3) step();
    chk("t4_level", level, 4);
    chk("t4_ovf", ovf, 1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("t4_ovf_cleared", ovf, 0);
    ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_order", cap_data, exp_c[i]);
      step();
    end
    ready = 1'b0;
    chk("t4_drained", level, 0);

    // full FIFO with a pop in the same cycle as a new capture
    for (int i = 0; i < 4; i++) begin
      ev = 1'b0; repeat (2) step();
      ev = 1'b1; repeat (2) step();
    end
    ev = 1'b0; repeat (3) step();
    chk("t5_full", level, 4);
    ev = 1'b1; step(); step();
    ready = 1'b1; step(); ready = 1'b0;
    chk("t5_level_kept", level, 4);
    chk("t5_no_ovf", ovf, 0);
    drain();

    // captures across counter wrap, then asynchronous reset
    ev = 1'b0; repeat (3) step();
    count = 16'hFFFC; ev = 1'b1; repeat (3) step();
    ev = 1'b0; repeat (2) step();
    count = 16'hFFFF; ev = 1'b1; repeat (3) step();
    chk("t6_level", level, 2);
    chk("t6_first", cap_data, 16'hFFFE);
    ready = 1'b1; step(); ready = 1'b0;
    chk("t6_second", cap_data, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_level", level, 0);
    chk("t6_async_valid", cap_valid, 0);
    repeat (2) step();
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) ev = ~ev;
      if ($urandom_range(0, 63) == 0) sel = 2'($urandom_range(0, 3));
      ready = ($urandom_range(0, 99) < (((n / 500) % 2) != 0 ? 80 : 20));
      clr   = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 255) == 0) count = 16'($urandom);
      rst_n = ($urandom_range(0, 1499) != 0);
      step();
    end
    rst_n = 1'b1; ready = 1'b0; clr = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
